pc_sequencer: RTL and testbench

//  Control FSM that sequences program_counter: selects next_pc, gates PC writes, and raises pipeline flush.

---
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: arbitrates fetch, redirects, stalls, overflow traps and halt.
// Define PC_SEQ_TRAP_EN to enable the overflow trap / eret path (disabled by default).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_pc,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        overflow_flag,
  input  logic        eret,
  input  logic        halt,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        flush,
  output logic [31:0] epc,
  output logic        trap_active,
  output logic        halted
);

`ifdef PC_SEQ_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StRun = 2'd0, StTrap = 2'd1, StHalt = 2'd2} state_e;

  state_e      state_q;
  logic [3:0]  flush_cnt_q;
  logic [31:0] epc_q;
  logic        trap_active_q;
  logic        halted_q;

  logic redirect, hold_cnt, go_halt, take_trap, take_eret, mask_flush;

  always_comb begin
    next_pc    = current_pc + PC_STEP;
    pc_write   = 1'b1;
    redirect   = 1'b0;
    hold_cnt   = 1'b0;
    go_halt    = 1'b0;
    take_trap  = 1'b0;
    take_eret  = 1'b0;
    mask_flush = 1'b0;
    if (rst) begin
      next_pc  = RESET_PC;
      pc_write = 1'b0;
    end else if (state_q == StHalt) begin
      next_pc  = current_pc;
      pc_write = 1'b0;
    end else if (halt) begin
      next_pc  = current_pc;
      pc_write = 1'b0;
      go_halt  = 1'b1;
    end else if (overflow_flag && state_q == StRun) begin
      if (TrapEn) begin
        next_pc   = TRAP_VECTOR;
        redirect  = 1'b1;
        take_trap = 1'b1;
      end else begin
        // Without the trap path the faulting PC simply holds.
        next_pc    = current_pc;
        pc_write   = 1'b0;
        mask_flush = 1'b1;
      end
    end else if (eret && state_q == StTrap) begin
      next_pc   = epc_q + PC_STEP;
      redirect  = 1'b1;
      take_eret = 1'b1;
    end else if (stall) begin
      next_pc  = current_pc;
      pc_write = 1'b0;
      hold_cnt = 1'b1;
    end else if (jump) begin
      next_pc  = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = branch_target;
      redirect = 1'b1;
    end

    if (rst) begin
      flush = 1'b1;
    end else if (state_q == StHalt || mask_flush) begin
      flush = 1'b0;
    end else begin
      flush = redirect | (flush_cnt_q != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      flush_cnt_q   <= 4'd0;
      epc_q         <= 32'd0;
      trap_active_q <= 1'b0;
      halted_q      <= 1'b0;
    end else if (go_halt) begin
      state_q     <= StHalt;
      halted_q    <= 1'b1;
      flush_cnt_q <= 4'd0;
    end else if (take_trap) begin
      state_q       <= StTrap;
      epc_q         <= current_pc;
      trap_active_q <= 1'b1;
      flush_cnt_q   <= FlushLoad;
    end else if (take_eret) begin
      state_q       <= StRun;
      trap_active_q <= 1'b0;
      flush_cnt_q   <= FlushLoad;
    end else if (redirect) begin
      flush_cnt_q <= FlushLoad;
    end else if (!hold_cnt && flush_cnt_q != 4'd0) begin
      flush_cnt_q <= flush_cnt_q - 4'd1;
    end
  end

  assign epc         = epc_q;
  assign trap_active = trap_active_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic vs a reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;
  localparam int unsigned FC          = 3;
`ifdef PC_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, overflow_flag, eret, halt;
  logic [31:0] current_pc, branch_target, jump_target;
  logic [31:0] next_pc, epc;
  logic        pc_write, flush, trap_active, halted;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC(RESET_PC), .PC_STEP(PC_STEP), .TRAP_VECTOR(TRAP_VECTOR), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst), .current_pc(current_pc), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .overflow_flag(overflow_flag), .eret(eret), .halt(halt),
    .next_pc(next_pc), .pc_write(pc_write), .flush(flush), .epc(epc),
    .trap_active(trap_active), .halted(halted)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural PC register plus sequencer bookkeeping.
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_epc = 32'd0;
  bit          m_in_trap = 1'b0;
  bit          m_halted = 1'b0;
  int          m_flush_left = 0;

  logic [31:0] obs_npc;
  logic        obs_wr, obs_fl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit st, input bit br, input bit jp, input bit ov,
                      input bit er, input bit hl, input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] e_npc;
    bit          e_wr, e_fl, npc_care, redir;
    rst = r; stall = st; branch_taken = br; jump = jp; overflow_flag = ov;
    eret = er; halt = hl; branch_target = bt; jump_target = jt; current_pc = m_pc;
    @(negedge clk);
    obs_npc = next_pc; obs_wr = pc_write; obs_fl = flush;

    // Registered outputs reflect the model state before this edge.
    check("epc", epc, m_epc);
    check("trap_active", {31'd0, trap_active}, {31'd0, m_in_trap});
    check("halted", {31'd0, halted}, {31'd0, m_halted});

    npc_care = 1'b1; redir = 1'b0; e_wr = 1'b1; e_npc = m_pc + PC_STEP; e_fl = 1'b0;
    if (r) begin
      e_npc = RESET_PC; e_wr = 1'b0; e_fl = 1'b1;
      m_pc = RESET_PC; m_epc = 0; m_in_trap = 0; m_halted = 0; m_flush_left = 0;
    end else if (m_halted) begin
      npc_care = 1'b0; e_wr = 1'b0; e_fl = 1'b0;
    end else if (hl) begin
      npc_care = 1'b0; e_wr = 1'b0; e_fl = (m_flush_left > 0);
      m_halted = 1; m_flush_left = 0;
    end else if (ov && !m_in_trap && !TRAP_EN) begin
      npc_care = 1'b0; e_wr = 1'b0; e_fl = 1'b0;
      if (m_flush_left > 0) m_flush_left--;
    end else if (ov && !m_in_trap) begin
      e_npc = TRAP_VECTOR; redir = 1'b1; m_epc = m_pc; m_in_trap = 1;
    end else if (er && m_in_trap) begin
      e_npc = m_epc + PC_STEP; redir = 1'b1; m_in_trap = 0;
    end else if (st) begin
      npc_care = 1'b0; e_wr = 1'b0; e_fl = (m_flush_left > 0);
    end else begin
      if (jp) begin e_npc = jt; redir = 1'b1; end
      else if (br) begin e_npc = bt; redir = 1'b1; end
      e_fl = (m_flush_left > 0);
      if (m_flush_left > 0) m_flush_left--;
    end
    if (redir) begin
      e_fl = 1'b1; m_flush_left = FC - 1;
    end
    if (e_wr) m_pc = e_npc;

    if (npc_care) check("next_pc", obs_npc, e_npc);
    check("pc_write", {31'd0, obs_wr}, {31'd0, e_wr});
    check("flush", {31'd0, obs_fl}, {31'd0, e_fl});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
  endtask

  int flush_hi;

  initial begin
    rst = 1; stall = 0; branch_taken = 0; jump = 0; overflow_flag = 0; eret = 0; halt = 0;
    branch_target = 0; jump_target = 0; current_pc = 0;
    @(posedge clk); #1;

    // Reset for two cycles, then sequential fetch from RESET_PC.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_flush", {31'd0, obs_fl}, 32'd1);
    idle(1);
    check("seq_first", obs_npc, 32'h4);
    idle(2);
    check("seq_third", obs_npc, 32'hC);

    // Jump beats branch; flush spans FC cycles.
    m_pc = 32'h10;
    step(0, 0, 1, 1, 0, 0, 0, 32'h200, 32'h40);
    check("jump_wins", obs_npc, 32'h40);
    flush_hi = int'(obs_fl);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      flush_hi += int'(obs_fl);
    end
    check("flush_len", flush_hi, FC);

    // Stall suppresses a pending branch until it drops.
    m_pc = 32'h20;
    step(0, 1, 1, 0, 0, 0, 0, 32'h60, 32'd0);
    check("stall_wr", {31'd0, obs_wr}, 32'd0);
    step(0, 0, 1, 0, 0, 0, 0, 32'h60, 32'd0);
    check("post_stall", obs_npc, 32'h60);
    idle(3);

    // Overflow at 0x24: trap when enabled, otherwise hold.
    m_pc = 32'h24;
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    if (TRAP_EN) begin
      check("trap_vec", obs_npc, TRAP_VECTOR);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0);
      check("trap_epc", epc, 32'h24);
      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("eret_pc", obs_npc, 32'h28);
    end else begin
      check("ovf_hold", {31'd0, obs_wr}, 32'd0);
      idle(1);
      check("ovf_epc", epc, 32'd0);
    end
    idle(3);

    // Halt ignores jumps until reset.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 32'h100);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", obs_npc, RESET_PC);
    idle(1);

    // Modulo-2^32 wrap.
    m_pc = 32'hFFFF_FFFC;
    idle(1);
    check("wrap", obs_npc, 32'h0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 20,
           $urandom_range(99) < 15, $urandom_range(99) < 10, $urandom_range(99) < 15,
           $urandom_range(199) < 1, {$urandom, 2'b00}, {$urandom, 2'b00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
